// File: rtl/onchip_mem_pkg.sv
// Shared widths and types for the on-chip RAM arbiter and its read-tag pipeline.
package onchip_mem_pkg;

   localparam int MEM_ADDR_W = 17;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_BE_W-1:0]   be;
      logic [MEM_DATA_W-1:0] wdata;
      logic                  wr;
   } mem_req_t;

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// Read-tag delay line matching the RAM read latency; reset drops every pending read.
module onchip_mem_rd_pipe
   import onchip_mem_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t push,
   output rd_tag_t tail
);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("onchip_mem_rd_pipe: READ_LATENCY must be 1 or 2");
   end

   rd_tag_t [READ_LATENCY-1:0] stage_q;
   rd_tag_t [READ_LATENCY-1:0] stage_d;

   always_comb begin
      stage_d    = '0;
      stage_d[0] = push;
      for (int i = 1; i < READ_LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tail = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin front end for the single-port on-chip RAM; one access per cycle,
// read data returned READ_LATENCY cycles after the grant and steered to the issuing master.
module onchip_mem_arbiter
   import onchip_mem_pkg::*;
#(
   parameter  int ADDR_W       = MEM_ADDR_W,
   parameter  int DATA_W       = MEM_DATA_W,
   parameter  int READ_LATENCY = 1,
   localparam int BE_W         = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_bad_width
      $error("onchip_mem_arbiter: ADDR_W/DATA_W must match onchip_mem_pkg");
   end

   logic     req0, req1, allow, gnt0, gnt1, gnt_any;
   logic     last_gnt_q, last_gnt_d;
   mem_req_t req0_s, req1_s, win;
   rd_tag_t  push, tail;

   always_comb begin
      req0    = m0_read | m0_write;
      req1    = m1_read | m1_write;
      allow   = ~reset & ~reset_req;
      // last_gnt_q high means m1 was served last, so m0 takes the next tie
      gnt0    = allow & req0 & (~req1 | last_gnt_q);
      gnt1    = allow & req1 & (~req0 | ~last_gnt_q);
      gnt_any = gnt0 | gnt1;

      last_gnt_d = last_gnt_q;
      if (gnt_any) begin
         last_gnt_d = gnt1;
      end

      req0_s = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata, wr: m0_write};
      req1_s = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata, wr: m1_write};
      win    = gnt1 ? req1_s : req0_s;

      // write wins over a simultaneous read, so only a pure read is tagged
      push = '{valid: gnt_any & ~win.wr, id: gnt1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   onchip_mem_rd_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_rd_pipe (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .tail (tail)
   );

   assign m0_waitrequest   = ~gnt0;
   assign m1_waitrequest   = ~gnt1;
   assign m0_readdatavalid = ~reset & tail.valid & ~tail.id;
   assign m1_readdatavalid = ~reset & tail.valid & tail.id;
   assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

   assign mem_address    = win.addr;
   assign mem_byteenable = win.be;
   assign mem_writedata  = win.wdata;
   assign mem_chipselect = gnt_any;
   assign mem_write      = gnt_any & win.wr;
   assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench: two arbiter instances (read latency 1 and 2) on shared master stimulus, each with a RAM model;
// expected read responses are queued at issue time and checked by a per-cycle monitor.
module tb_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset, reset_req;
   logic [16:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;

   logic        a_m0_waitrequest, a_m1_waitrequest, a_m0_readdatavalid, a_m1_readdatavalid;
   logic [31:0] a_m0_readdata, a_m1_readdata, a_mem_writedata, a_mem_readdata;
   logic [16:0] a_mem_address;
   logic [3:0]  a_mem_byteenable;
   logic        a_mem_chipselect, a_mem_write, a_mem_clken;

   logic        b_m0_waitrequest, b_m1_waitrequest, b_m0_readdatavalid, b_m1_readdatavalid;
   logic [31:0] b_m0_readdata, b_m1_readdata, b_mem_writedata, b_mem_readdata;
   logic [16:0] b_mem_address;
   logic [3:0]  b_mem_byteenable;
   logic        b_mem_chipselect, b_mem_write, b_mem_clken;

   onchip_mem_arbiter #(.READ_LATENCY(1)) dut_a (
      .clk(clk), .reset(reset), .reset_req(reset_req),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_m0_waitrequest),
      .m0_readdata(a_m0_readdata), .m0_readdatavalid(a_m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_m1_waitrequest),
      .m1_readdata(a_m1_readdata), .m1_readdatavalid(a_m1_readdatavalid),
      .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
      .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
      .mem_writedata(a_mem_writedata), .mem_clken(a_mem_clken), .mem_readdata(a_mem_readdata)
   );

   onchip_mem_arbiter #(.READ_LATENCY(2)) dut_b (
      .clk(clk), .reset(reset), .reset_req(reset_req),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_m0_waitrequest),
      .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_m1_waitrequest),
      .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_readdatavalid),
      .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
      .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
      .mem_writedata(b_mem_writedata), .mem_clken(b_mem_clken), .mem_readdata(b_mem_readdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM models: latency 1 = address registered, q unregistered; latency 2 adds an output register
   logic [31:0] ram_a [0:131071];
   logic [31:0] ram_b [0:131071];
   logic [31:0] qa1, qb1, qb2;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (a_mem_chipselect) begin
         if (a_mem_write) ram_a[a_mem_address] <= merge(ram_a[a_mem_address], a_mem_writedata, a_mem_byteenable);
         else qa1 <= ram_a[a_mem_address];
      end
      if (b_mem_chipselect) begin
         if (b_mem_write) ram_b[b_mem_address] <= merge(ram_b[b_mem_address], b_mem_writedata, b_mem_byteenable);
         else qb1 <= ram_b[b_mem_address];
      end
      qb2 <= qb1;
   end
   assign a_mem_readdata = qa1;
   assign b_mem_readdata = qb2;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   // index: 0 = lat1/m0, 1 = lat1/m1, 2 = lat2/m0, 3 = lat2/m1
   exp_t sbq [4][$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic mon(input int idx, input logic v, input logic [31:0] d, input int lat);
      exp_t e;
      if (v === 1'b1) begin
         if (sbq[idx].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_readdatavalid[%0d]: got valid data %h expected no valid (cycle %0d)", idx, d, cyc);
         end else begin
            e = sbq[idx].pop_front();
            chk($sformatf("readdata[%0d]", idx), d, e.data);
            chk($sformatf("read_latency[%0d]", idx), 32'(cyc - e.cyc), 32'(lat));
         end
      end else if (sbq[idx].size() != 0 && cyc - sbq[idx][0].cyc > lat) begin
         e = sbq[idx].pop_front();
         n_chk++;
         $display("FAIL missing_readdatavalid[%0d]: got no valid expected data %h (grant cycle %0d)", idx, e.data, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_m0_readdatavalid, a_m0_readdata, 1);
      mon(1, a_m1_readdatavalid, a_m1_readdata, 1);
      mon(2, b_m0_readdatavalid, b_m0_readdata, 2);
      mon(3, b_m1_readdatavalid, b_m1_readdata, 2);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
   endtask

   // Called after inputs are set for the current cycle; eg0/eg1 are the hand-derived grants,
   // ed0/ed1 the data a granted read of that master must return.
   task automatic expect_gnt(input logic eg0, input logic eg1,
                             input logic [31:0] ed0, input logic [31:0] ed1);
      #1;
      chk("a_m0_waitrequest", 32'(a_m0_waitrequest), 32'(!eg0));
      chk("a_m1_waitrequest", 32'(a_m1_waitrequest), 32'(!eg1));
      chk("b_m0_waitrequest", 32'(b_m0_waitrequest), 32'(!eg0));
      chk("b_m1_waitrequest", 32'(b_m1_waitrequest), 32'(!eg1));
      chk("mem_chipselect", 32'(a_mem_chipselect), 32'(eg0 | eg1));
      if (eg0) begin
         chk("m0_mem_address", 32'(a_mem_address), 32'(m0_address));
         chk("m0_mem_write", 32'(a_mem_write), 32'(m0_write));
         if (m0_write) begin
            chk("m0_mem_writedata", a_mem_writedata, m0_writedata);
            chk("m0_mem_byteenable", 32'(a_mem_byteenable), 32'(m0_byteenable));
         end else begin
            sbq[0].push_back('{ed0, cyc});
            sbq[2].push_back('{ed0, cyc});
         end
      end
      if (eg1) begin
         chk("m1_mem_address", 32'(a_mem_address), 32'(m1_address));
         chk("m1_mem_write", 32'(a_mem_write), 32'(m1_write));
         if (m1_write) begin
            chk("m1_mem_writedata", a_mem_writedata, m1_writedata);
            chk("m1_mem_byteenable", 32'(a_mem_byteenable), 32'(m1_byteenable));
         end else begin
            sbq[1].push_back('{ed1, cyc});
            sbq[3].push_back('{ed1, cyc});
         end
      end
   endtask

   task automatic check_rst();
      #1;
      chk("rst_a_m0_waitrequest", 32'(a_m0_waitrequest), 32'd1);
      chk("rst_a_m1_waitrequest", 32'(a_m1_waitrequest), 32'd1);
      chk("rst_b_m0_waitrequest", 32'(b_m0_waitrequest), 32'd1);
      chk("rst_b_m1_waitrequest", 32'(b_m1_waitrequest), 32'd1);
      chk("rst_mem_chipselect", 32'(a_mem_chipselect), 32'd0);
      chk("rst_mem_write", 32'(a_mem_write), 32'd0);
      chk("rst_a_m0_readdatavalid", 32'(a_m0_readdatavalid), 32'd0);
      chk("rst_a_m0_readdata", a_m0_readdata, 32'd0);
      chk("rst_b_m0_readdatavalid", 32'(b_m0_readdatavalid), 32'd0);
      chk("rst_b_m1_readdata", b_m1_readdata, 32'd0);
      chk("rst_mem_clken", 32'(a_mem_clken), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before timeout");
      $fatal(1);
   end

   initial begin
      int n0, n1;
      reset = 1'b1; reset_req = 1'b0;
      idle_inputs();
      m0_address = 17'h0; m1_address = 17'h0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      m0_writedata = 32'h0; m1_writedata = 32'h0;
      m0_write = 1'b1; m1_read = 1'b1;
      next_cycle();
      next_cycle();
      check_rst();

      next_cycle(); reset = 1'b0; idle_inputs();
      expect_gnt(0, 0, 0, 0);

      // write then read back by m0
      next_cycle(); m0_write = 1; m0_address = 17'h10; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      expect_gnt(1, 0, 0, 0);
      next_cycle(); m0_write = 0; m0_read = 1;
      expect_gnt(1, 0, 32'hDEADBEEF, 0);
      next_cycle(); idle_inputs();
      expect_gnt(0, 0, 0, 0);

      // preload for contention: last grant ends on m1
      next_cycle(); m1_write = 1; m1_address = 17'h20; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'hF;
      expect_gnt(0, 1, 0, 0);
      next_cycle(); m1_write = 0; m0_write = 1; m0_address = 17'h11; m0_writedata = 32'h11111111;
      expect_gnt(1, 0, 0, 0);
      next_cycle(); m0_write = 0; m1_write = 1; m1_address = 17'h21; m1_writedata = 32'h21212121;
      expect_gnt(0, 1, 0, 0);

      // both masters read continuously: m0 first, then strict alternation
      n0 = 0; n1 = 0;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         idle_inputs();
         m0_read = 1; m0_address = 17'(32'h10 + n0 % 2);
         m1_read = 1; m1_address = 17'(32'h20 + n1 % 2);
         expect_gnt(i % 2 == 0, i % 2 == 1,
                    (n0 % 2 == 1) ? 32'h11111111 : 32'hDEADBEEF,
                    (n1 % 2 == 1) ? 32'h21212121 : 32'hCAFEF00D);
         if (i % 2 == 0) n0++; else n1++;
      end

      // lone master gets every cycle
      for (int i = 0; i < 3; i++) begin
         next_cycle(); idle_inputs(); m1_read = 1; m1_address = 17'(32'h20 + i % 2);
         expect_gnt(0, 1, 0, (i % 2 == 1) ? 32'h21212121 : 32'hCAFEF00D);
      end

      // partial write at top address, read-after-write by the other master
      next_cycle(); idle_inputs(); m1_write = 1; m1_address = 17'h1FFFF; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
      expect_gnt(0, 1, 0, 0);
      next_cycle(); m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
      expect_gnt(0, 1, 0, 0);
      next_cycle(); idle_inputs(); m0_read = 1; m0_address = 17'h1FFFF;
      expect_gnt(1, 0, 32'hFFFF5678, 0);

      // reset_req window with a read in flight
      next_cycle(); m0_address = 17'h10;
      expect_gnt(1, 0, 32'hDEADBEEF, 0);
      for (int i = 0; i < 3; i++) begin
         next_cycle(); reset_req = 1; m1_read = 1; m1_address = 17'h20;
         expect_gnt(0, 0, 0, 0);
      end
      next_cycle(); reset_req = 0;
      expect_gnt(0, 1, 0, 32'hCAFEF00D);
      next_cycle(); m1_read = 0;
      expect_gnt(1, 0, 32'hDEADBEEF, 0);

      // reset one cycle after a read grant drops it and restores m0 priority
      next_cycle(); idle_inputs(); m0_read = 1; m0_address = 17'h11;
      expect_gnt(1, 0, 32'h11111111, 0);
      next_cycle(); reset = 1; idle_inputs(); m0_write = 1; m1_read = 1;
      for (int i = 0; i < 4; i++) sbq[i].delete();
      check_rst();
      next_cycle(); reset = 0; idle_inputs();
      m0_read = 1; m0_address = 17'h10; m1_read = 1; m1_address = 17'h20;
      expect_gnt(1, 0, 32'hDEADBEEF, 0);
      next_cycle();
      expect_gnt(0, 1, 0, 32'hCAFEF00D);

      // read+write together is a write only
      next_cycle(); idle_inputs(); m0_read = 1; m0_write = 1; m0_address = 17'h30;
      m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'hF;
      expect_gnt(1, 0, 0, 0);
      next_cycle(); m0_write = 0;
      expect_gnt(1, 0, 32'hA5A5A5A5, 0);

      next_cycle(); idle_inputs();
      expect_gnt(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) next_cycle();
      for (int i = 0; i < 4; i++) chk($sformatf("pending_reads[%0d]", i), 32'(sbq[i].size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
